instr_sequencer: RTL and testbench

Program-driven replacement for the hard-wired Fibonacci test controller: it fetches 16-bit instructions from a synchronous instruction memory, decodes them, and drives the register-file write enables, ALU operand muxes and ALU opcode. It sits directly upstream of the regfile/ALU datapath. Its output port set matches the existing controller's outputs plus an immediate bus, so the datapath connects without change.

---
 rtl/isa_pkg.sv | 34 +++
 rtl/instr_decode.sv | 47 ++++
 rtl/instr_sequencer.sv | 98 +++++++++
 tb/tb_instr_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Instruction-set constants, field layout and sequencer state encoding
// shared by the instruction sequencer and its decoder.
package isa_pkg;

  localparam logic [7:0]  OPC_ADD   = 8'h05;
  localparam logic [7:0]  OPC_ADDI  = 8'h50;
  localparam logic [7:0]  OPC_NOP   = 8'h00;
  localparam logic [3:0]  OP_RTYPE  = 4'h0;
  localparam logic [3:0]  EXT_CMP   = 4'hB;
  localparam logic [3:0]  OP_CMPI   = 4'hB;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;
  localparam logic [15:0] NOP_WORD  = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_EXEC,
    ST_HALTED
  } seq_state_e;

  // Field slices: op [15:12], rdest [11:8], ext [7:4], rsrc [3:0]; imm8 = {ext, rsrc}.
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rdest;
    logic [3:0] ext;
    logic [3:0] rsrc;
  } instr_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: IR word to ALU/regfile controls.
// reg_en_pre is the raw one-hot Rdest; the caller gates it with no_write and EXEC.
module instr_decode
  import isa_pkg::*;
(
  input  logic [15:0] ir,
  output logic [15:0] reg_en_pre,
  output logic [3:0]  mux_a,
  output logic [3:0]  mux_b,
  output logic        mux_bimm,
  output logic [7:0]  opcode,
  output logic [15:0] imm,
  output logic        is_halt,
  output logic        no_write
);

  instr_t f;
  assign f = instr_t'(ir);

  always_comb begin
    reg_en_pre = 16'd1 << f.rdest;
    mux_a      = f.rdest;
    mux_b      = f.rsrc;
    mux_bimm   = 1'b0;
    opcode     = {4'b0000, f.ext};
    imm        = '0;
    is_halt    = 1'b0;
    no_write   = 1'b0;
    if (ir == HALT_WORD) begin
      // HALT presents a NOP-like control set so nothing downstream reacts.
      is_halt  = 1'b1;
      no_write = 1'b1;
      mux_a    = '0;
      mux_b    = '0;
      opcode   = OPC_NOP;
    end else if (f.op == OP_RTYPE) begin
      no_write = (ir == NOP_WORD) || (f.ext == EXT_CMP);
    end else begin
      opcode   = {f.op, 4'b0000};
      mux_bimm = 1'b1;
      mux_b    = '0;
      imm      = sext8({f.ext, f.rsrc});
      no_write = (f.op == OP_CMPI);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/latch/exec sequencer driving the regfile/ALU datapath from a synchronous
// instruction memory; 3 cycles per instruction, HALT parks until reset.
module instr_sequencer
  import isa_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRd,
  input  logic [15:0]       memData,
  output logic [15:0]       regEn,
  output logic [3:0]        muxA,
  output logic [3:0]        muxB,
  output logic              muxBimm,
  output logic [7:0]        Opcode,
  output logic [15:0]       imm,
  output logic              halted
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;

  logic [15:0] reg_en_pre;
  logic [3:0]  dec_mux_a;
  logic [3:0]  dec_mux_b;
  logic        dec_mux_bimm;
  logic [7:0]  dec_opcode;
  logic [15:0] dec_imm;
  logic        is_halt;
  logic        no_write;

  // IR only changes entering EXEC, so decoding it continuously also holds the
  // last executed controls through the following FETCH/LATCH/IDLE.
  instr_decode u_decode (
    .ir         (ir_q),
    .reg_en_pre (reg_en_pre),
    .mux_a      (dec_mux_a),
    .mux_b      (dec_mux_b),
    .mux_bimm   (dec_mux_bimm),
    .opcode     (dec_opcode),
    .imm        (dec_imm),
    .is_halt    (is_halt),
    .no_write   (no_write)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= NOP_WORD;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_LATCH;
      ST_LATCH: begin
        ir_d    = memData;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_halt) begin
          state_d = ST_HALTED;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    memRd   = (state_q == ST_FETCH);
    memAddr = pc_q;
    regEn   = (state_q == ST_EXEC && !no_write) ? reg_en_pre : 16'h0000;
    muxA    = dec_mux_a;
    muxB    = dec_mux_b;
    muxBimm = dec_mux_bimm;
    Opcode  = dec_opcode;
    imm     = dec_imm;
    halted  = (state_q == ST_HALTED);
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a 16-bit-address instance and a 2-bit-address
// instance, each fed by a registered ROM model.
module tb_instr_sequencer;
  import isa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;

  logic        rst_a, run_a, memRd_a, muxBimm_a, halted_a;
  logic [15:0] memAddr_a, memData_a, regEn_a, imm_a;
  logic [3:0]  muxA_a, muxB_a;
  logic [7:0]  Opcode_a;
  logic [15:0] rom_a [16];

  logic        rst_b, run_b, memRd_b, muxBimm_b, halted_b;
  logic [1:0]  memAddr_b;
  logic [15:0] memData_b, regEn_b, imm_b;
  logic [3:0]  muxA_b, muxB_b;
  logic [7:0]  Opcode_b;
  logic [15:0] rom_b [4];

  instr_sequencer #(.ADDR_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .run(run_a), .memAddr(memAddr_a), .memRd(memRd_a),
    .memData(memData_a), .regEn(regEn_a), .muxA(muxA_a), .muxB(muxB_a),
    .muxBimm(muxBimm_a), .Opcode(Opcode_a), .imm(imm_a), .halted(halted_a)
  );

  instr_sequencer #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .run(run_b), .memAddr(memAddr_b), .memRd(memRd_b),
    .memData(memData_b), .regEn(regEn_b), .muxA(muxA_b), .muxB(muxB_b),
    .muxBimm(muxBimm_b), .Opcode(Opcode_b), .imm(imm_b), .halted(halted_b)
  );

  initial begin
    memData_a = '0;
    memData_b = '0;
  end

  always @(posedge clk) begin
    if (memRd_a) memData_a <= rom_a[memAddr_a[3:0]];
    if (memRd_b) memData_b <= rom_b[memAddr_b];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int rd_cnt;
    rst_a = 1'b1; run_a = 1'b0;
    rst_b = 1'b1; run_b = 1'b0;
    for (int i = 0; i < 16; i++) rom_a[i] = 16'h0000;
    step(); step();
    rst_a = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (memRd_a) rd_cnt++;
    end
    tot++; if (rd_cnt !== 0) begin bad++; $display("FAIL reset_memrd got=%0d want=0", rd_cnt); end
    tot++; if (memAddr_a !== 16'h0000) begin bad++; $display("FAIL reset_memaddr got=%h want=0000", memAddr_a); end
    tot++; if (regEn_a !== 16'h0000) begin bad++; $display("FAIL reset_regen got=%h want=0000", regEn_a); end
    tot++; if ({muxA_a, muxB_a, muxBimm_a} !== 9'h000) begin bad++; $display("FAIL reset_mux got=%h/%h/%b want=0/0/0", muxA_a, muxB_a, muxBimm_a); end
    tot++; if ({Opcode_a, imm_a} !== 24'h000000) begin bad++; $display("FAIL reset_opimm got=%h/%h want=00/0000", Opcode_a, imm_a); end
    tot++; if (halted_a !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted_a); end
  endtask

  task automatic test_program_halt();
    int rd_cnt;
    rom_a[0] = 16'h5001; rom_a[1] = 16'h0251; rom_a[2] = 16'h52FF; rom_a[3] = 16'hFFFF;
    run_a = 1'b1;
    step();
    tot++; if ({memRd_a, memAddr_a} !== {1'b1, 16'h0000}) begin bad++; $display("FAIL fetch0 got=%b/%h want=1/0000", memRd_a, memAddr_a); end
    step();
    tot++; if ({memRd_a, regEn_a} !== 17'h00000) begin bad++; $display("FAIL latch0 got=%b/%h want=0/0000", memRd_a, regEn_a); end
    step();
    tot++; if (regEn_a !== 16'h0001) begin bad++; $display("FAIL addi_regen got=%h want=0001", regEn_a); end
    tot++; if ({muxA_a, muxBimm_a} !== 5'b0000_1) begin bad++; $display("FAIL addi_mux got=%h/%b want=0/1", muxA_a, muxBimm_a); end
    tot++; if (Opcode_a !== OPC_ADDI) begin bad++; $display("FAIL addi_opcode got=%h want=%h", Opcode_a, OPC_ADDI); end
    tot++; if (imm_a !== 16'h0001) begin bad++; $display("FAIL addi_imm got=%h want=0001", imm_a); end
    step();
    tot++; if ({memRd_a, memAddr_a, regEn_a} !== {1'b1, 16'h0001, 16'h0000}) begin bad++; $display("FAIL fetch1 got=%b/%h/%h want=1/0001/0000", memRd_a, memAddr_a, regEn_a); end
    tot++; if (Opcode_a !== 8'h50) begin bad++; $display("FAIL hold_opcode got=%h want=50", Opcode_a); end
    step(); step();
    tot++; if (regEn_a !== 16'h0004) begin bad++; $display("FAIL add_regen got=%h want=0004", regEn_a); end
    tot++; if ({muxA_a, muxB_a, muxBimm_a} !== {4'h2, 4'h1, 1'b0}) begin bad++; $display("FAIL add_mux got=%h/%h/%b want=2/1/0", muxA_a, muxB_a, muxBimm_a); end
    tot++; if (Opcode_a !== 8'h05) begin bad++; $display("FAIL add_opcode got=%h want=05", Opcode_a); end
    step(); step(); step();
    tot++; if ({regEn_a, imm_a} !== {16'h0004, 16'hFFFF}) begin bad++; $display("FAIL neg_imm got=%h/%h want=0004/ffff", regEn_a, imm_a); end
    tot++; if ({muxB_a, muxBimm_a} !== {4'h0, 1'b1}) begin bad++; $display("FAIL neg_mux got=%h/%b want=0/1", muxB_a, muxBimm_a); end
    step(); step(); step();
    tot++; if ({regEn_a, halted_a} !== 17'h00000) begin bad++; $display("FAIL halt_exec got=%h/%b want=0000/0", regEn_a, halted_a); end
    step();
    tot++; if (halted_a !== 1'b1) begin bad++; $display("FAIL halted_rise got=%b want=1", halted_a); end
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (memRd_a || !halted_a || regEn_a != 16'h0000) rd_cnt++;
    end
    tot++; if (rd_cnt !== 0) begin bad++; $display("FAIL halted_quiet got=%0d want=0", rd_cnt); end
    tot++; if (memAddr_a !== 16'h0003) begin bad++; $display("FAIL halt_pc got=%h want=0003", memAddr_a); end
    rst_a = 1'b1;
    step();
    tot++; if ({halted_a, memAddr_a} !== 17'h00000) begin bad++; $display("FAIL halt_rst got=%b/%h want=0/0000", halted_a, memAddr_a); end
  endtask

  task automatic test_nowrite();
    rom_a[0] = 16'h0000; rom_a[1] = 16'h03B4; rom_a[2] = 16'hB305; rom_a[3] = 16'hFFFF;
    rst_a = 1'b0; run_a = 1'b1;
    step(); step(); step();
    tot++; if ({regEn_a, Opcode_a} !== 24'h000000) begin bad++; $display("FAIL nop_exec got=%h/%h want=0000/00", regEn_a, Opcode_a); end
    step(); step(); step();
    tot++; if (regEn_a !== 16'h0000) begin bad++; $display("FAIL cmp_regen got=%h want=0000", regEn_a); end
    tot++; if ({Opcode_a, muxA_a, muxB_a} !== {8'h0B, 4'h3, 4'h4}) begin bad++; $display("FAIL cmp_ctl got=%h/%h/%h want=0b/3/4", Opcode_a, muxA_a, muxB_a); end
    step(); step(); step();
    tot++; if (regEn_a !== 16'h0000) begin bad++; $display("FAIL cmpi_regen got=%h want=0000", regEn_a); end
    tot++; if ({Opcode_a, imm_a, muxBimm_a} !== {8'hB0, 16'h0005, 1'b1}) begin bad++; $display("FAIL cmpi_ctl got=%h/%h/%b want=b0/0005/1", Opcode_a, imm_a, muxBimm_a); end
  endtask

  task automatic test_rst_mid_exec();
    rst_a = 1'b1;
    step();
    rom_a[0] = 16'h5001; rom_a[1] = 16'h5101;
    rst_a = 1'b0; run_a = 1'b1;
    step(); step(); step();
    tot++; if (regEn_a !== 16'h0001) begin bad++; $display("FAIL pre_rst_exec got=%h want=0001", regEn_a); end
    rst_a = 1'b1;
    step();
    tot++; if ({regEn_a, memRd_a, memAddr_a, Opcode_a} !== 41'h0) begin bad++; $display("FAIL rst_exec got=%h/%b/%h/%h want=0000/0/0000/00", regEn_a, memRd_a, memAddr_a, Opcode_a); end
    rst_a = 1'b0;
    step();
    tot++; if ({memRd_a, memAddr_a} !== {1'b1, 16'h0000}) begin bad++; $display("FAIL rst_refetch got=%b/%h want=1/0000", memRd_a, memAddr_a); end
    run_a = 1'b0;
  endtask

  task automatic test_wrap_run_drop();
    logic [1:0]  exp_addr;
    logic [15:0] exp_en;
    int          pulses;
    int          rd_cnt;
    rom_b[0] = 16'h5101; rom_b[1] = 16'h5201; rom_b[2] = 16'h5301; rom_b[3] = 16'h5401;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0; run_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_addr = 2'(i);
      exp_en = 16'd1 << (exp_addr + 3'd1);
      step();
      tot++; if ({memRd_b, memAddr_b} !== {1'b1, exp_addr}) begin bad++; $display("FAIL wrap_fetch%0d got=%b/%h want=1/%h", i, memRd_b, memAddr_b, exp_addr); end
      step(); step();
      tot++; if (regEn_b !== exp_en) begin bad++; $display("FAIL wrap_exec%0d got=%h want=%h", i, regEn_b, exp_en); end
    end
    step(); step();
    run_b = 1'b0;
    pulses = 0;
    rd_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (regEn_b != 16'h0000) pulses++;
      if (memRd_b) rd_cnt++;
      if (i == 0) begin
        tot++; if (regEn_b !== 16'h0004) begin bad++; $display("FAIL drop_exec got=%h want=0004", regEn_b); end
      end
    end
    tot++; if (pulses !== 1) begin bad++; $display("FAIL drop_pulses got=%0d want=1", pulses); end
    tot++; if ({rd_cnt, memAddr_b} !== {32'd0, 2'd2}) begin bad++; $display("FAIL drop_idle got=%0d/%h want=0/2", rd_cnt, memAddr_b); end
    run_b = 1'b1;
    step();
    tot++; if ({memRd_b, memAddr_b} !== {1'b1, 2'd2}) begin bad++; $display("FAIL resume got=%b/%h want=1/2", memRd_b, memAddr_b); end
  endtask

  initial begin
    test_reset();
    test_program_halt();
    test_nowrite();
    test_rst_mid_exec();
    test_wrap_run_drop();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
